// File: rtl/datapath_pkg.sv
// Shared widths and ALU opcodes for the single-bus datapath.
// Imported by the ALU and the datapath top.
package datapath_pkg;

  localparam int WIDTH = 32;
  localparam int NREGS = 16;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_INC  = 5'b11111;

endpackage

// File: rtl/datapath_new_alu.sv
// Combinational ALU: a (from Y) op b (from bus) -> 64-bit c.
// Ports: a, b (32), opcode (5) in; c (64) out.
module alu
  import datapath_pkg::*;
(
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [4:0]         opcode,
  output logic [2*WIDTH-1:0] c
);

  logic [4:0]         sh;
  logic [2*WIDTH-1:0] rot_r;
  logic [2*WIDTH-1:0] rot_l;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  assign sh = b[4:0];

  // Rotates via a doubled word; sh = 0 falls out as a pass-through.
  assign rot_r = {a, a} >> sh;
  assign rot_l = {a, a} << sh;

  // Signed divide on magnitudes so -2^31 / -1 wraps cleanly.
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;
  assign q_mag = (b_mag == '0) ? '0 : a_mag / b_mag;
  assign r_mag = (b_mag == '0) ? '0 : a_mag % b_mag;
  assign quo   = (a[WIDTH-1] ^ b[WIDTH-1]) ? -q_mag : q_mag;
  assign rem   = a[WIDTH-1] ? -r_mag : r_mag;

  always_comb begin
    c = '0;
    case (opcode)
      OP_ADD:  c[WIDTH-1:0] = a + b;
      OP_SUB:  c[WIDTH-1:0] = a - b;
      OP_AND:  c[WIDTH-1:0] = a & b;
      OP_OR:   c[WIDTH-1:0] = a | b;
      OP_SHR:  c[WIDTH-1:0] = a >> sh;
      OP_SHRA: c[WIDTH-1:0] = $signed(a) >>> sh;
      OP_SHL:  c[WIDTH-1:0] = a << sh;
      OP_ROR:  c[WIDTH-1:0] = rot_r[WIDTH-1:0];
      OP_ROL:  c[WIDTH-1:0] = rot_l[2*WIDTH-1:WIDTH];
      OP_MUL:  c = $signed({{WIDTH{a[WIDTH-1]}}, a})
                 * $signed({{WIDTH{b[WIDTH-1]}}, b});
      OP_DIV: begin
        if (b == '0) begin
          c = {a, {WIDTH{1'b1}}};
        end else begin
          c = {rem, quo};
        end
      end
      OP_NEG:  c[WIDTH-1:0] = -b;
      OP_NOT:  c[WIDTH-1:0] = ~b;
      OP_INC:  c[WIDTH-1:0] = b + 1'b1;
      default: c = '0;
    endcase
  end

endmodule

// File: rtl/datapath_new.sv
// Single-bus CPU datapath: R0-R15, PC, IR, MDR, Y, Z, HI, LO, C + ALU.
// Strobes *in load from the bus; *out select the bus source by priority.
module datapath_new
  import datapath_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] Mdatain,
  input  logic [31:0] in_port_data,
  input  logic        Read,
  input  logic        r0in,  r1in,  r2in,  r3in,
  input  logic        r4in,  r5in,  r6in,  r7in,
  input  logic        r8in,  r9in,  r10in, r11in,
  input  logic        r12in, r13in, r14in, r15in,
  input  logic        y_in,
  input  logic        ir_in,
  input  logic        pc_in,
  input  logic        hi_in,
  input  logic        lo_in,
  input  logic        Cin,
  input  logic        MDRin,
  input  logic        zhi_in,
  input  logic        zlo_in,
  input  logic        r0out,  r1out,  r2out,  r3out,
  input  logic        r4out,  r5out,  r6out,  r7out,
  input  logic        r8out,  r9out,  r10out, r11out,
  input  logic        r12out, r13out, r14out, r15out,
  input  logic        hiout,
  input  logic        loout,
  input  logic        zhighout,
  input  logic        zlowout,
  input  logic        pcout,
  input  logic        mdrout,
  input  logic        in_portout,
  input  logic        cout,
  input  logic [4:0]  opcode,
  output logic [31:0] bus_q,
  output logic [31:0] ir_q,
  output logic [31:0] pc_q,
  output logic [31:0] mdr_q
);

  localparam int NSRC = NREGS + 8;

  logic [NREGS-1:0]            rin;
  logic [NREGS-1:0]            rout;
  logic [NREGS-1:0][WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0]            y_q, y_d;
  logic [WIDTH-1:0]            zhi_q, zhi_d;
  logic [WIDTH-1:0]            zlo_q, zlo_d;
  logic [WIDTH-1:0]            hi_q, hi_d;
  logic [WIDTH-1:0]            lo_q, lo_d;
  logic [WIDTH-1:0]            c_q, c_d;
  logic [WIDTH-1:0]            ir_d, pc_d, mdr_d;
  logic [2*WIDTH-1:0]          alu_c;
  logic [NSRC-1:0]             sel;
  logic [NSRC-1:0][WIDTH-1:0]  src;

  assign rin  = {r15in, r14in, r13in, r12in, r11in, r10in, r9in, r8in,
                 r7in,  r6in,  r5in,  r4in,  r3in,  r2in,  r1in, r0in};
  assign rout = {r15out, r14out, r13out, r12out,
                 r11out, r10out, r9out,  r8out,
                 r7out,  r6out,  r5out,  r4out,
                 r3out,  r2out,  r1out,  r0out};

  // Index 0 is highest priority.
  assign sel = {cout, in_portout, mdrout, pcout,
                zlowout, zhighout, loout, hiout, rout};
  assign src = {c_q, in_port_data, mdr_q, pc_q,
                zlo_q, zhi_q, lo_q, hi_q, r_q};

  always_comb begin
    bus_q = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (sel[i]) bus_q = src[i];
    end
  end

  alu u_alu (
    .a      (y_q),
    .b      (bus_q),
    .opcode (opcode),
    .c      (alu_c)
  );

  always_comb begin
    r_d = r_q;
    for (int i = 0; i < NREGS; i++) begin
      if (rin[i]) r_d[i] = bus_q;
    end
    y_d   = y_in   ? bus_q : y_q;
    ir_d  = ir_in  ? bus_q : ir_q;
    pc_d  = pc_in  ? bus_q : pc_q;
    hi_d  = hi_in  ? bus_q : hi_q;
    lo_d  = lo_in  ? bus_q : lo_q;
    c_d   = Cin    ? bus_q : c_q;
    zhi_d = zhi_in ? alu_c[2*WIDTH-1:WIDTH] : zhi_q;
    zlo_d = zlo_in ? alu_c[WIDTH-1:0] : zlo_q;
    mdr_d = mdr_q;
    if (MDRin) mdr_d = Read ? Mdatain : bus_q;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_q   <= '0;
      y_q   <= '0;
      ir_q  <= '0;
      pc_q  <= '0;
      mdr_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      c_q   <= '0;
      zhi_q <= '0;
      zlo_q <= '0;
    end else begin
      r_q   <= r_d;
      y_q   <= y_d;
      ir_q  <= ir_d;
      pc_q  <= pc_d;
      mdr_q <= mdr_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      c_q   <= c_d;
      zhi_q <= zhi_d;
      zlo_q <= zlo_d;
    end
  end

endmodule

// File: tb/tb_datapath_new.sv
// Directed bench for datapath_new: ALU vector table plus
// hand-written bus, load, reset and PC sequences.
module tb_datapath_new;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] Mdatain, in_port_data;
  logic        Read;
  logic [15:0] rin, rout;
  logic        y_in, ir_in, pc_in, hi_in, lo_in, Cin, MDRin;
  logic        zhi_in, zlo_in;
  logic        hiout, loout, zhighout, zlowout;
  logic        pcout, mdrout, in_portout, cout;
  logic [4:0]  opcode;
  logic [31:0] bus_q, ir_q, pc_q, mdr_q;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  datapath_new dut (
    .clk(clk), .clr(clr), .Mdatain(Mdatain),
    .in_port_data(in_port_data), .Read(Read),
    .r0in(rin[0]),   .r1in(rin[1]),   .r2in(rin[2]),
    .r3in(rin[3]),   .r4in(rin[4]),   .r5in(rin[5]),
    .r6in(rin[6]),   .r7in(rin[7]),   .r8in(rin[8]),
    .r9in(rin[9]),   .r10in(rin[10]), .r11in(rin[11]),
    .r12in(rin[12]), .r13in(rin[13]), .r14in(rin[14]),
    .r15in(rin[15]),
    .y_in(y_in), .ir_in(ir_in), .pc_in(pc_in),
    .hi_in(hi_in), .lo_in(lo_in), .Cin(Cin), .MDRin(MDRin),
    .zhi_in(zhi_in), .zlo_in(zlo_in),
    .r0out(rout[0]),   .r1out(rout[1]),   .r2out(rout[2]),
    .r3out(rout[3]),   .r4out(rout[4]),   .r5out(rout[5]),
    .r6out(rout[6]),   .r7out(rout[7]),   .r8out(rout[8]),
    .r9out(rout[9]),   .r10out(rout[10]), .r11out(rout[11]),
    .r12out(rout[12]), .r13out(rout[13]), .r14out(rout[14]),
    .r15out(rout[15]),
    .hiout(hiout), .loout(loout), .zhighout(zhighout),
    .zlowout(zlowout), .pcout(pcout), .mdrout(mdrout),
    .in_portout(in_portout), .cout(cout),
    .opcode(opcode),
    .bus_q(bus_q), .ir_q(ir_q), .pc_q(pc_q), .mdr_q(mdr_q)
  );

  typedef struct {
    string       name;
    logic [31:0] y;
    logic [31:0] b;
    logic [4:0]  op;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [22];

  task automatic idle();
    clr = 0; Read = 0; rin = '0; rout = '0;
    y_in = 0; ir_in = 0; pc_in = 0; hi_in = 0; lo_in = 0;
    Cin = 0; MDRin = 0; zhi_in = 0; zlo_in = 0;
    hiout = 0; loout = 0; zhighout = 0; zlowout = 0;
    pcout = 0; mdrout = 0; in_portout = 0; cout = 0;
    opcode = 5'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic load_mdr(logic [31:0] v);
    idle(); Read = 1; Mdatain = v; MDRin = 1;
    tick(); idle();
  endtask

  task automatic set_y(logic [31:0] v);
    load_mdr(v);
    mdrout = 1; y_in = 1;
    tick(); idle();
  endtask

  task automatic load_reg(int k, logic [31:0] v);
    load_mdr(v);
    mdrout = 1; rin[k] = 1;
    tick(); idle();
  endtask

  task automatic read_reg(string nm, int k, logic [31:0] exp);
    idle(); rout[k] = 1; #1;
    check(nm, bus_q, exp);
    idle();
  endtask

  task automatic alu_run(vec_t v);
    set_y(v.y);
    load_mdr(v.b);
    mdrout = 1; opcode = v.op; zhi_in = 1; zlo_in = 1;
    tick(); idle();
    zhighout = 1; #1;
    check({v.name, ".hi"}, bus_q, v.hi);
    idle(); zlowout = 1; #1;
    check({v.name, ".lo"}, bus_q, v.lo);
    idle();
  endtask

  initial begin
    vecs[0]  = '{"add",   32'h12, 32'h14, 5'b00011, 32'h0, 32'h26};
    vecs[1]  = '{"sub",   32'h5, 32'h7, 5'b00100, 32'h0, 32'hFFFFFFFE};
    vecs[2]  = '{"and",   32'hF0F0F0F0, 32'h0FF00FF0, 5'b00101,
                 32'h0, 32'h00F000F0};
    vecs[3]  = '{"or",    32'hF0F00000, 32'h0000000F, 5'b00110,
                 32'h0, 32'hF0F0000F};
    vecs[4]  = '{"shr",   32'h80000000, 32'h4, 5'b00111,
                 32'h0, 32'h08000000};
    vecs[5]  = '{"shra",  32'h80000000, 32'h4, 5'b01000,
                 32'h0, 32'hF8000000};
    vecs[6]  = '{"shl",   32'h1, 32'd31, 5'b01001, 32'h0, 32'h80000000};
    vecs[7]  = '{"shl5b", 32'h1, 32'h21, 5'b01001, 32'h0, 32'h2};
    vecs[8]  = '{"ror",   32'h1, 32'h1, 5'b01010, 32'h0, 32'h80000000};
    vecs[9]  = '{"ror0",  32'h12345678, 32'h0, 5'b01010,
                 32'h0, 32'h12345678};
    vecs[10] = '{"rol",   32'h80000000, 32'h4, 5'b01011, 32'h0, 32'h8};
    vecs[11] = '{"mul",   32'hFFFFFFFE, 32'h3, 5'b01111,
                 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[12] = '{"mulbig", 32'h00010000, 32'h00010000, 5'b01111,
                 32'h1, 32'h0};
    vecs[13] = '{"div",   32'h7, 32'h2, 5'b10000, 32'h1, 32'h3};
    vecs[14] = '{"divna", 32'hFFFFFFF9, 32'h2, 5'b10000,
                 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[15] = '{"divnb", 32'h7, 32'hFFFFFFFE, 5'b10000,
                 32'h1, 32'hFFFFFFFD};
    vecs[16] = '{"div0",  32'h5, 32'h0, 5'b10000, 32'h5, 32'hFFFFFFFF};
    vecs[17] = '{"neg",   32'h9, 32'h1, 5'b10001, 32'h0, 32'hFFFFFFFF};
    vecs[18] = '{"not",   32'h9, 32'h0F0F0F0F, 5'b10010,
                 32'h0, 32'hF0F0F0F0};
    vecs[19] = '{"inc",   32'h9, 32'hFFFFFFFF, 5'b11111, 32'h0, 32'h0};
    vecs[20] = '{"op0",   32'h5, 32'h5, 5'b00000, 32'h0, 32'h0};
    vecs[21] = '{"op0c",  32'h5, 32'h5, 5'b01100, 32'h0, 32'h0};

    idle();
    Mdatain = 32'h0; in_port_data = 32'hCAFE0001;

    // Reset
    clr = 1; tick(); tick(); idle(); #1;
    check("rst.ir", ir_q, 32'h0);
    check("rst.pc", pc_q, 32'h0);
    check("rst.mdr", mdr_q, 32'h0);
    check("rst.bus", bus_q, 32'h0);
    load_mdr(32'h12);
    check("mdr.load", mdr_q, 32'h12);

    // Register loads
    load_reg(2, 32'h12);
    load_reg(3, 32'h14);
    load_reg(1, 32'h18);
    read_reg("r2", 2, 32'h12);
    read_reg("r3", 3, 32'h14);
    read_reg("r1", 1, 32'h18);

    // ADD R2+R3 -> R1
    rout[2] = 1; y_in = 1; tick(); idle();
    rout[3] = 1; opcode = 5'b00011; zhi_in = 1; zlo_in = 1;
    tick(); idle();
    zlowout = 1; rin[1] = 1; tick(); idle();
    read_reg("add.r1", 1, 32'h26);
    zhighout = 1; #1;
    check("add.zhi", bus_q, 32'h0);
    idle();

    // PC increment
    pcout = 1; opcode = 5'b11111; zlo_in = 1; tick(); idle();
    zlowout = 1; pc_in = 1; tick(); idle();
    check("pc.inc", pc_q, 32'h1);

    // Bus priority and self-load
    load_mdr(32'h12);
    rout[1] = 1; mdrout = 1; #1;
    check("prio.r1mdr", bus_q, 32'h26);
    idle(); #1;
    check("bus.none", bus_q, 32'h0);
    rout[2] = 1; rin[2] = 1; tick(); idle();
    read_reg("self.r2", 2, 32'h12);
    in_portout = 1; #1;
    check("bus.inport", bus_q, 32'hCAFE0001);
    idle();

    // MDR from bus (Read=0) and IR load
    rout[1] = 1; MDRin = 1; tick(); idle();
    check("mdr.bus", mdr_q, 32'h26);
    mdrout = 1; ir_in = 1; tick(); idle();
    check("ir.load", ir_q, 32'h26);

    // Parallel loads into HI, LO, C, R4, R5
    load_mdr(32'hA5A5_0003);
    mdrout = 1; hi_in = 1; lo_in = 1; Cin = 1;
    rin[4] = 1; rin[5] = 1; tick(); idle();
    read_reg("par.r4", 4, 32'hA5A50003);
    read_reg("par.r5", 5, 32'hA5A50003);
    hiout = 1; #1; check("par.hi", bus_q, 32'hA5A50003); idle();
    cout = 1; #1; check("par.c", bus_q, 32'hA5A50003); idle();
    load_mdr(32'h44); mdrout = 1; lo_in = 1; tick(); idle();
    hiout = 1; loout = 1; #1;
    check("prio.hilo", bus_q, 32'hA5A50003); idle();
    loout = 1; pcout = 1; mdrout = 1; cout = 1; #1;
    check("prio.lopc", bus_q, 32'h44); idle();
    pcout = 1; mdrout = 1; in_portout = 1; #1;
    check("prio.pcmdr", bus_q, 32'h1); idle();
    mdrout = 1; in_portout = 1; cout = 1; #1;
    check("prio.mdrin", bus_q, 32'h44); idle();

    // Register priority across the whole file
    for (int k = 0; k < 16; k++) begin
      load_reg(k, 32'h1000 + k);
    end
    for (int k = 0; k < 16; k++) begin
      idle();
      for (int j = k; j < 16; j++) rout[j] = 1;
      hiout = 1; pcout = 1; cout = 1; #1;
      check($sformatf("prio.r%0d", k), bus_q, 32'h1000 + k);
    end
    idle();

    // ALU table
    for (int i = 0; i < 22; i++) alu_run(vecs[i]);

    // Reset priority over strobes
    for (int k = 0; k < 16; k++) load_reg(k, 32'h77 + k);
    set_y(32'h31);
    idle(); clr = 1; Read = 1; Mdatain = 32'h99; MDRin = 1;
    pc_in = 1; ir_in = 1; hi_in = 1; lo_in = 1; Cin = 1;
    zlo_in = 1; zhi_in = 1; opcode = 5'b00011; in_portout = 1;
    rin = '1; y_in = 1;
    tick(); idle();
    check("clr.mdr", mdr_q, 32'h0);
    check("clr.pc", pc_q, 32'h0);
    check("clr.ir", ir_q, 32'h0);
    for (int k = 0; k < 16; k++) begin
      read_reg($sformatf("clr.r%0d", k), k, 32'h0);
    end
    hiout = 1; #1; check("clr.hi", bus_q, 32'h0); idle();
    loout = 1; #1; check("clr.lo", bus_q, 32'h0); idle();
    cout = 1; #1; check("clr.c", bus_q, 32'h0); idle();
    zlowout = 1; #1; check("clr.zlo", bus_q, 32'h0); idle();
    zhighout = 1; #1; check("clr.zhi", bus_q, 32'h0); idle();
    load_mdr(32'h5);
    mdrout = 1; opcode = 5'b00011; zlo_in = 1; tick(); idle();
    zlowout = 1; #1; check("clr.y", bus_q, 32'h5); idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/datapath_new.md
Name: datapath_new

Overview:
- 32-bit single-bus CPU datapath: register file R0–R15, PC, IR, MDR, Y, 64-bit Z (Zhi/Zlo), HI, LO, C, and a combinational ALU.
- One shared 32-bit bus is driven by a priority encoder/mux from the *out strobes.
- Registers load from the bus on the rising clock edge when their *in strobe is high.
- The control unit (or a bench) sequences all strobes; this block has no internal FSM.

Parameters:
- WIDTH, 32, datapath word width. Fixed; the other values below assume 32.
- NREGS, 16, number of general registers.

Ports:
- clk in 1: system clock; all state changes on its rising edge.
- clr in 1: reset. Synchronous, active-high; zeroes every register on a rising clk.
- Mdatain in 32: memory read data into MDR.
- in_port_data in 32: external input-port value.
- Read in 1: selects the MDR input source; 1 = Mdatain, 0 = bus.
- r0in..r15in in 1 each: load Rn from the bus.
- y_in, ir_in, pc_in, hi_in, lo_in, Cin in 1 each: load Y, IR, PC, HI, LO, C from the bus.
- MDRin in 1: load MDR from the Read-selected source.
- zhi_in in 1: load Zhi from ALU result[63:32].
- zlo_in in 1: load Zlo from ALU result[31:0].
- r0out..r15out, hiout, loout, zhighout, zlowout, pcout, mdrout, in_portout, cout in 1 each: bus source selects.
- opcode in 5: ALU operation select.
- bus_q out 32: current bus value.
- ir_q, pc_q, mdr_q out 32 each: current IR, PC and MDR contents.

Behaviour:
- Reset: on a rising clk with clr=1, all registers go to 0. This includes R0–R15, PC, IR, MDR, Y, Zhi, Zlo, HI, LO and C. clr has priority over every load strobe.
- Register loads: enabled registers capture their input at the rising edge; 1-cycle latency.
- Bus: purely combinational.
  - Priority order: r0out > r1out > … > r15out > hiout > loout > zhighout > zlowout > pcout > mdrout > in_portout > cout.
  - No strobe active → bus = 0.
- MDR: next value = Read ? Mdatain : bus. Loads only when MDRin=1.
- ALU: operand A = Y, operand B = bus. Produces a 64-bit result C; Zhi/Zlo load its halves independently.
- Opcodes (all 32-bit ops set C[63:32] = 0 unless noted):
  - 00011 add: A+B, modulo 2^32.
  - 00100 sub: A−B.
  - 00101 and.
  - 00110 or.
  - 00111 shr: logical right, shift amount B[4:0].
  - 01000 shra: arithmetic right.
  - 01001 shl: left shift.
  - 01010 ror: rotate right.
  - 01011 rol: rotate left.
  - 01111 mul: signed A×B, full 64-bit product.
  - 10000 div: signed A÷B, truncating toward zero.
    - Quotient → C[31:0]; remainder (sign of dividend) → C[63:32].
    - B=0: C[31:0] = 32'hFFFFFFFF, C[63:32] = A.
  - 10001 neg: −B.
  - 10010 not: ~B.
  - 11111 inc: B+1 (PC increment).
  - Any other code: C = 0.
- Simultaneous events:
  - Multiple *in strobes load in parallel.
  - A register that is both bus source and destination captures its own old value.
  - Shift amount 0 passes A unchanged.
- Overflow and carry are not flagged.

Decomposition:
- Package datapath_pkg: WIDTH, opcode localparams (OP_ADD … OP_INC).
- One sub-module, alu: combinational; inputs A, B, opcode; output 64-bit C.
- Bus mux and registers live in datapath_new.

Test Plan:
- Reset: assert clr for one edge → all *_q and bus = 0. Then drive Mdatain=32'h12, Read=1, MDRin=1 without clr → mdr_q = 32'h12.
- Register load: MDR=32'h12, mdrout+r2in for one edge → then r2out alone gives bus = 32'h12. Repeat with 32'h14→R3 and 32'h18→R1 → each reads back.
- ADD: R2=32'h12, R3=32'h14.
  - r2out+y_in.
  - Then r3out, opcode=00011, zhi_in+zlo_in.
  - Then zlowout+r1in → R1 = 32'h26; zhighout gives 0.
- PC increment: PC=0, pcout with opcode=11111 and zlo_in; then zlowout+pc_in → pc_q = 1.
- MUL/DIV:
  - Y=32'hFFFFFFFE (−2), bus=3, mul → Zhi=32'hFFFFFFFF, Zlo=32'hFFFFFFFA.
  - Y=7, bus=2, div → Zlo=3, Zhi=1.
  - Divide by zero → Zlo=32'hFFFFFFFF.
- Bus priority and shifts:
  - r1out and mdrout together → bus shows R1.
  - Y=32'h80000000, bus=4: shra → 32'hF8000000; shr → 32'h08000000; rol → 32'h00000008.
